// File: rtl/des_pkg.sv
// Shared widths, round count and FSM state type for the DES core arbiter.
package des_pkg;
  localparam int DES_BLK_W  = 64;
  localparam int DES_KEY_W  = 64;
  localparam int DES_ROUNDS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;
endpackage

// File: rtl/des_core_arbiter_if.sv
// Bus bundle around the DES arbiter: two request ports, the response port and the core link.
interface des_core_arbiter_if
  import des_pkg::*;
#(
  parameter int BLK_W = DES_BLK_W,
  parameter int KEY_W = DES_KEY_W
);
  logic             req0_valid;
  logic             req0_ready;
  logic [BLK_W-1:0] req0_data;
  logic [KEY_W-1:0] req0_key;
  logic             req1_valid;
  logic             req1_ready;
  logic [BLK_W-1:0] req1_data;
  logic [KEY_W-1:0] req1_key;
  logic             resp_valid;
  logic             resp_ready;
  logic [BLK_W-1:0] resp_data;
  logic             resp_id;
  logic             resp_err;
  logic             busy;
  logic             core_start;
  logic [BLK_W-1:0] core_din;
  logic [KEY_W-1:0] core_key;
  logic             core_ready;
  logic [BLK_W-1:0] core_dout;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_data, req0_key,
    input  req1_valid, req1_data, req1_key,
    input  resp_ready, core_ready, core_dout,
    output req0_ready, req1_ready,
    output resp_valid, resp_data, resp_id, resp_err, busy,
    output core_start, core_din, core_key
  );

  // Requesters, response consumer and core together.
  modport master (
    output req0_valid, req0_data, req0_key,
    output req1_valid, req1_data, req1_key,
    output resp_ready, core_ready, core_dout,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_data, resp_id, resp_err, busy,
    input  core_start, core_din, core_key
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone valid wins outright, a tie goes to the pointer's port.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant,
  output logic       grant_id
);
  assign grant_id = (valid == 2'b11) ? pointer : valid[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
      assign grant[gi] = valid[gi] && (grant_id == 1'(gi));
    end
  endgenerate
endmodule

// File: rtl/des_core_arbiter.sv
// Shares one iterative DES core between two requesters, one operation in flight at a time,
// with a watchdog that turns a silent core into an error response.
module des_core_arbiter
  import des_pkg::*;
#(
  parameter int BLK_W       = DES_BLK_W,
  parameter int KEY_W       = DES_KEY_W,
  parameter int TIMEOUT_CYC = 24
) (
  input  logic               clk,
  input  logic               rst,
  des_core_arbiter_if.slave  bus
);
  localparam int               CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t       state_reg;
  logic             ptr_reg;
  logic             id_reg;
  logic             start_reg;
  logic             busy_reg;
  logic             resp_valid_reg;
  logic             resp_err_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [BLK_W-1:0] din_reg;
  logic [KEY_W-1:0] key_reg;
  logic [BLK_W-1:0] resp_data_reg;

  logic [1:0]       req_valid;
  logic [1:0]       grant;
  logic             grant_id;
  logic             in_idle;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign in_idle   = (state_reg == IDLE);

  rr_arb2 u_arb (
    .valid    (req_valid),
    .pointer  (ptr_reg),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Ready is only offered while idle, so nothing is taken during an operation.
  assign bus.req0_ready = in_idle && grant[0];
  assign bus.req1_ready = in_idle && grant[1];

  assign bus.core_start = start_reg;
  assign bus.core_din   = din_reg;
  assign bus.core_key   = key_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_data  = resp_data_reg;
  assign bus.resp_id    = id_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.busy       = busy_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      ptr_reg        <= 1'b0;
      id_reg         <= 1'b0;
      start_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      cnt_reg        <= '0;
      din_reg        <= '0;
      key_reg        <= '0;
      resp_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // din/key are written only here; the core re-reads the key every round.
          if (|grant) begin
            din_reg   <= grant_id ? bus.req1_data : bus.req0_data;
            key_reg   <= grant_id ? bus.req1_key  : bus.req0_key;
            id_reg    <= grant_id;
            start_reg <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          start_reg <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (bus.core_ready) begin
            resp_data_reg  <= bus.core_dout;
            resp_err_reg   <= 1'b0;
            resp_valid_reg <= 1'b1;
            state_reg      <= RESP;
          end else if (cnt_reg == CNT_LAST) begin
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b1;
            resp_valid_reg <= 1'b1;
            state_reg      <= RESP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            ptr_reg        <= ~id_reg;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_des_core_arbiter.sv
// Directed bench for des_core_arbiter: a cycle-accurate reference model checked every cycle,
// plus known-answer and latency literals per scenario.
module tb_des_core_arbiter;
  import des_pkg::*;

  localparam int          TIMEOUT = 24;
  localparam logic [63:0] PT_A    = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT_A    = 64'h85E813540F0AB405;
  localparam logic [63:0] CT_Z    = 64'h8CA64DE9C1B123A7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_core_arbiter_if #(.BLK_W(64), .KEY_W(64)) bus ();

  des_core_arbiter #(
    .BLK_W       (64),
    .KEY_W       (64),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit core_hang = 1'b0;

  // Known DES answers; other inputs get an arbitrary but deterministic stand-in cipher.
  function automatic logic [63:0] kat(input logic [63:0] d, input logic [63:0] k);
    if (d == PT_A && k == KEY_A) return CT_A;
    if (d == 64'h0 && k == 64'h0) return CT_Z;
    return d ^ {k[31:0], k[63:32]} ^ 64'hA5A5_0F0F_3C3C_9696;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Iterative core stand-in: start clears the round count, ready is a level once 16 rounds are done.
  int  rounds;
  bit  running;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rounds  <= 0;
      running <= 1'b0;
    end else if (bus.core_start) begin
      rounds  <= 0;
      running <= 1'b1;
    end else if (running && rounds < DES_ROUNDS) begin
      rounds <= rounds + 1;
    end
  end
  assign bus.core_ready = running && (rounds == DES_ROUNDS) && !core_hang;
  assign bus.core_dout  = bus.core_ready ? kat(bus.core_din, bus.core_key) : 64'hDEAD_BEEF_DEAD_BEEF;

  // Reference model: timing follows from accept cycle arithmetic, not from any state encoding.
  int          cyc = 0;
  bit          m_busy, m_ptr, m_id, m_err;
  int          m_acc, m_resp;
  logic [63:0] m_din, m_key, m_dout;

  initial begin
    bit v0, v1, g;
    m_busy = 1'b0; m_ptr = 1'b0; m_id = 1'b0; m_err = 1'b0;
    m_acc = 0; m_resp = 0; m_din = '0; m_key = '0; m_dout = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_busy",       bus.busy, 0);
        chk("rst_core_start", bus.core_start, 0);
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_req1_ready", bus.req1_ready, 0);
        chk("rst_resp_data",  bus.resp_data, 0);
        chk("rst_resp_id",    bus.resp_id, 0);
        chk("rst_resp_err",   bus.resp_err, 0);
        chk("rst_core_din",   bus.core_din, 0);
        chk("rst_core_key",   bus.core_key, 0);
        m_busy = 1'b0; m_ptr = 1'b0; m_din = '0; m_key = '0;
      end else if (!m_busy) begin
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        g  = (v0 && v1) ? m_ptr : v1;
        chk("idle_req0_ready",  bus.req0_ready, 64'(v0 && !g));
        chk("idle_req1_ready",  bus.req1_ready, 64'(v1 && g));
        chk("idle_busy",        bus.busy, 0);
        chk("idle_resp_valid",  bus.resp_valid, 0);
        chk("idle_core_start",  bus.core_start, 0);
        chk("idle_core_din",    bus.core_din, m_din);
        chk("idle_core_key",    bus.core_key, m_key);
        if (v0 || v1) begin
          m_busy = 1'b1;
          m_acc  = cyc;
          m_id   = g;
          m_din  = g ? bus.req1_data : bus.req0_data;
          m_key  = g ? bus.req1_key  : bus.req0_key;
          if (core_hang) begin
            m_resp = cyc + 2 + TIMEOUT;
            m_dout = '0;
            m_err  = 1'b1;
          end else begin
            m_resp = cyc + 3 + DES_ROUNDS;
            m_dout = kat(m_din, m_key);
            m_err  = 1'b0;
          end
        end
      end else begin
        chk("op_req0_ready",  bus.req0_ready, 0);
        chk("op_req1_ready",  bus.req1_ready, 0);
        chk("op_busy",        bus.busy, 1);
        chk("op_core_start",  bus.core_start, 64'(cyc == m_acc + 1));
        chk("op_core_din",    bus.core_din, m_din);
        chk("op_core_key",    bus.core_key, m_key);
        chk("op_resp_valid",  bus.resp_valid, 64'(cyc >= m_resp));
        if (cyc >= m_resp) begin
          chk("op_resp_data", bus.resp_data, m_dout);
          chk("op_resp_id",   bus.resp_id, 64'(m_id));
          chk("op_resp_err",  bus.resp_err, 64'(m_err));
          if (bus.resp_ready) begin
            m_busy = 1'b0;
            m_ptr  = !m_id;
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit port, input bit valid, input logic [63:0] d, input logic [63:0] k);
    if (port) begin
      bus.req1_valid = valid; bus.req1_data = d; bus.req1_key = k;
    end else begin
      bus.req0_valid = valid; bus.req0_data = d; bus.req0_key = k;
    end
  endtask

  // Called one cycle after the accept edge; lat counts cycles from the accept cycle.
  task automatic wait_resp(output bit id, output logic [63:0] data, output bit err, output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 100) begin
      tick;
      lat++;
    end
    chk("resp_arrives", bus.resp_valid, 1);
    id   = bus.resp_id;
    data = bus.resp_data;
    err  = bus.resp_err;
    $display("resp id=%0d data=%h err=%0d latency=%0d", id, data, err, lat);
  endtask

  task automatic run_op(input bit port, input logic [63:0] d, input logic [63:0] k,
                        output bit id, output logic [63:0] data, output bit err, output int lat);
    set_req(port, 1'b1, d, k);
    #1;
    chk("op_accept_ready", port ? bus.req1_ready : bus.req0_ready, 1);
    tick;
    if (port) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    wait_resp(id, data, err, lat);
    tick;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          id, err;
    logic [63:0] data, held;
    int          lat;

    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_key = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_key = '0;
    bus.resp_ready = 1'b1;
    tick;
    chk("reset_busy",       bus.busy, 0);
    chk("reset_resp_valid", bus.resp_valid, 0);
    chk("reset_core_din",   bus.core_din, 0);
    tick;
    rst = 1'b0;
    tick;

    // Single known-answer request on port 0.
    run_op(1'b0, PT_A, KEY_A, id, data, err, lat);
    chk("t1_latency", lat, 19);
    chk("t1_data", data, CT_A);
    chk("t1_id", id, 0);
    chk("t1_err", err, 0);

    // Simultaneous requests straight after reset: port 0 first, port 1 waits.
    do_reset;
    set_req(1'b0, 1'b1, 64'h0, 64'h0);
    set_req(1'b1, 1'b1, PT_A, KEY_A);
    #1;
    chk("t2_req0_ready", bus.req0_ready, 1);
    chk("t2_req1_ready", bus.req1_ready, 0);
    tick;
    bus.req0_valid = 1'b0;
    wait_resp(id, data, err, lat);
    chk("t2_first_data", data, CT_Z);
    chk("t2_first_id", id, 0);
    tick;
    chk("t2_req1_ready_idle", bus.req1_ready, 1);
    tick;
    bus.req1_valid = 1'b0;
    wait_resp(id, data, err, lat);
    chk("t2_second_data", data, CT_A);
    chk("t2_second_id", id, 1);
    tick;

    // Port 1 held valid, port 0 pulsing: grants must alternate 0,1,0,1.
    set_req(1'b1, 1'b1, 64'hFEDC_BA98_7654_3210, 64'h0E32_9232_EA6D_0D73);
    for (int i = 0; i < 4; i++) begin
      set_req(1'b0, 1'b1, 64'h1000_0000_0000_0000 + 64'(i), 64'h5555_AAAA_5555_AAAA);
      #1;
      chk("b2b_req0_ready", bus.req0_ready, 64'(i % 2 == 0));
      chk("b2b_req1_ready", bus.req1_ready, 64'(i % 2 == 1));
      tick;
      bus.req0_valid = 1'b0;
      wait_resp(id, data, err, lat);
      chk("b2b_id", id, 64'(i % 2));
      tick;
    end
    bus.req1_valid = 1'b0;

    // Backpressure with port 0 still requesting.
    bus.resp_ready = 1'b0;
    set_req(1'b0, 1'b1, PT_A, KEY_A);
    #1;
    chk("bp_accept_ready", bus.req0_ready, 1);
    tick;
    bus.req0_data = 64'h0;
    bus.req0_key  = 64'h0;
    wait_resp(id, data, err, lat);
    chk("bp_latency", lat, 19);
    held = data;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_data_stable", bus.resp_data, held);
      chk("bp_id_stable", bus.resp_id, 64'(id));
      chk("bp_err_stable", bus.resp_err, 64'(err));
      chk("bp_req0_ready", bus.req0_ready, 0);
      chk("bp_busy", bus.busy, 1);
    end
    bus.resp_ready = 1'b1;
    tick;
    chk("bp_ready_after_hs", bus.req0_ready, 1);
    chk("bp_busy_after_hs", bus.busy, 0);
    tick;
    bus.req0_valid = 1'b0;
    wait_resp(id, data, err, lat);
    chk("bp_second_data", data, CT_Z);
    chk("bp_second_latency", lat, 19);
    tick;

    // Silent core: error response after 24 WAIT cycles, then normal service resumes.
    core_hang = 1'b1;
    run_op(1'b1, 64'h0F0F_0F0F_F0F0_F0F0, 64'h1234_5678_9ABC_DEF0, id, data, err, lat);
    chk("to_latency", lat, 26);
    chk("to_err", err, 1);
    chk("to_data", data, 0);
    chk("to_id", id, 1);
    core_hang = 1'b0;
    run_op(1'b0, PT_A, KEY_A, id, data, err, lat);
    chk("to_next_data", data, CT_A);
    chk("to_next_err", err, 0);
    chk("to_next_latency", lat, 19);

    // Reset in the middle of WAIT discards the operation.
    set_req(1'b0, 1'b1, PT_A, KEY_A);
    tick;
    bus.req0_valid = 1'b0;
    repeat (7) tick;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_resp_valid", bus.resp_valid, 0);
    chk("mid_rst_core_start", bus.core_start, 0);
    chk("mid_rst_core_key", bus.core_key, 0);
    chk("mid_rst_core_din", bus.core_din, 0);
    tick;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick;
      chk("mid_rst_no_resp", bus.resp_valid, 0);
    end
    run_op(1'b0, 64'h0, 64'h0, id, data, err, lat);
    chk("mid_rst_next_data", data, CT_Z);
    chk("mid_rst_next_id", id, 0);
    chk("mid_rst_next_latency", lat, 19);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
